// File: rtl/aes_sbox_pipe.sv
// AES S-box / inverse S-box pipeline, LANES parallel byte lanes.
// Each lane computes the GF(2^8) inverse and the affine map arithmetically.
// Two register stages, each with its own valid bit; ready/valid on both sides.
// Stage 1 holds the field inverse. For the forward direction the input goes
// straight into the inverter. For the inverse direction the inverse affine map
// is applied first. Stage 2 applies the forward affine map for mode 0 only, so
// one inverter per lane serves both modes.
module aes_sbox_pipe #(
  parameter int LANES = 4,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [8*LANES-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_mode,
  output logic [8*LANES-1:0]   out_data,
  output logic [CNT_W-1:0]     xfer_cnt
);

  localparam int DW = 8 * LANES;

  // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1 (shift-and-add).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p  = p ^ (aa & {8{b[i]}});
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; the chain yields 0 for a = 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] res;
    sq  = a;
    res = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      res = gf_mul(res, sq);
    end
    return res;
  endfunction

  // Forward affine map: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  function automatic logic [7:0] affine_fwd(input logic [7:0] b);
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] r3;
    logic [7:0] r4;
    r1 = {b[6:0], b[7]};
    r2 = {b[5:0], b[7:6]};
    r3 = {b[4:0], b[7:5]};
    r4 = {b[3:0], b[7:4]};
    return b ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
  endfunction

  // Inverse affine map: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
  function automatic logic [7:0] affine_inv(input logic [7:0] b);
    logic [7:0] r1;
    logic [7:0] r3;
    logic [7:0] r6;
    r1 = {b[6:0], b[7]};
    r3 = {b[4:0], b[7:5]};
    r6 = {b[1:0], b[7:2]};
    return r1 ^ r3 ^ r6 ^ 8'h05;
  endfunction

  // First-stage byte: optional inverse affine, then field inverse.
  function automatic logic [7:0] stage1_byte(input logic mode, input logic [7:0] b);
    logic [7:0] pre;
    pre = mode ? affine_inv(b) : b;
    return gf_inv(pre);
  endfunction

  // Second-stage byte: forward affine for SubBytes, pass-through for InvSubBytes.
  function automatic logic [7:0] stage2_byte(input logic mode, input logic [7:0] b);
    return mode ? b : affine_fwd(b);
  endfunction

  logic          r_s1_valid;
  logic          r_s1_mode;
  logic [DW-1:0] r_s1_data;
  logic          r_s2_valid;
  logic          r_s2_mode;
  logic [DW-1:0] r_s2_data;
  logic [CNT_W-1:0] r_xfer_cnt;

  logic [DW-1:0] w_s1_next;
  logic [DW-1:0] w_s2_next;
  logic          w_s2_adv;
  logic          w_in_ready;
  logic          w_in_xfer;
  logic          w_out_xfer;

  // Per-lane combinational substitution feeding each stage register.
  always_comb begin
    w_s1_next = '0;
    w_s2_next = '0;
    for (int i = 0; i < LANES; i++) begin
      w_s1_next[8*i +: 8] = stage1_byte(in_mode, in_data[8*i +: 8]);
      w_s2_next[8*i +: 8] = stage2_byte(r_s1_mode, r_s1_data[8*i +: 8]);
    end
  end

  // Handshake: stage 2 moves when empty or draining, stage 1 moves with it.
  always_comb begin
    w_s2_adv   = ~r_s2_valid | out_ready;
    w_in_ready = ~r_s1_valid | w_s2_adv;
    w_in_xfer  = in_valid & w_in_ready;
    w_out_xfer = r_s2_valid & out_ready;
  end

  // Stage 1 register: valid follows in_valid whenever the stage can move.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      if (w_in_ready) begin
        r_s1_valid <= in_valid;
      end else begin
        r_s1_valid <= r_s1_valid;
      end
      if (w_in_xfer) begin
        r_s1_mode <= in_mode;
        r_s1_data <= w_s1_next;
      end else begin
        r_s1_mode <= r_s1_mode;
        r_s1_data <= r_s1_data;
      end
    end
  end

  // Stage 2 register: holds the output beat stable while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_mode  <= 1'b0;
      r_s2_data  <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_mode <= r_s1_mode;
        r_s2_data <= w_s2_next;
      end else begin
        r_s2_mode <= r_s2_mode;
        r_s2_data <= r_s2_data;
      end
    end else begin
      r_s2_valid <= r_s2_valid;
      r_s2_mode  <= r_s2_mode;
      r_s2_data  <= r_s2_data;
    end
  end

  // Completed output transfer counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xfer_cnt <= '0;
    end else if (w_out_xfer) begin
      r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
    end else begin
      r_xfer_cnt <= r_xfer_cnt;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_s2_valid;
  assign out_mode  = r_s2_mode;
  assign out_data  = r_s2_data;
  assign xfer_cnt  = r_xfer_cnt;

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// Bench for aes_sbox_pipe: three builds (4 lanes/32-bit count, 16 lanes/4-bit
// count, 1 lane/8-bit count) share control and are checked against the
// FIPS-197 S-box table with a scoreboard, plus directed vectors and sequences.
module tb_aes_sbox_pipe;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam int NV = 6;

  typedef struct {
    logic        mode;
    logic [31:0] din;
    logic [31:0] dout;
  } vec_t;

  typedef struct packed {
    logic         mode;
    logic [31:0]  da;
    logic [127:0] db;
    logic [7:0]   dc;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_mode;
  logic         out_ready;
  logic [31:0]  a_in_data;
  logic [127:0] b_in_data;
  logic [7:0]   c_in_data;
  logic         a_in_ready, b_in_ready, c_in_ready;
  logic         a_out_valid, b_out_valid, c_out_valid;
  logic         a_out_mode, b_out_mode, c_out_mode;
  logic [31:0]  a_out_data;
  logic [127:0] b_out_data;
  logic [7:0]   c_out_data;
  logic [31:0]  a_xfer_cnt;
  logic [3:0]   b_xfer_cnt;
  logic [7:0]   c_xfer_cnt;

  int           checks = 0;
  int           failures = 0;
  logic [7:0]   isbox [256];
  vec_t         vecs [NV];
  ent_t         q[$];
  logic [31:0]  cnt_model = 32'd0;
  logic         stall_chk = 1'b0;
  logic         last_in_xfer = 1'b0;

  aes_sbox_pipe #(.LANES(4), .CNT_W(32)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_mode(in_mode),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(out_ready), .out_mode(a_out_mode),
    .out_data(a_out_data), .xfer_cnt(a_xfer_cnt));

  aes_sbox_pipe #(.LANES(16), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_mode(in_mode),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(out_ready), .out_mode(b_out_mode),
    .out_data(b_out_data), .xfer_cnt(b_xfer_cnt));

  aes_sbox_pipe #(.LANES(1), .CNT_W(8)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready), .in_mode(in_mode),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(out_ready), .out_mode(c_out_mode),
    .out_data(c_out_data), .xfer_cnt(c_xfer_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] sub_model(input logic mode, input logic [127:0] d, input int lanes);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < lanes; i++) begin
      r[8*i +: 8] = mode ? isbox[d[8*i +: 8]] : SBOX[d[8*i +: 8]];
    end
    return r;
  endfunction

  // Derive per-build lane data from one 32-bit seed; 16-lane bytes are distinct.
  task automatic set_data(input logic [31:0] d);
    a_in_data = d;
    for (int i = 0; i < 16; i++) begin
      b_in_data[8*i +: 8] = d[7:0] + 8'(17 * i);
    end
    c_in_data = d[15:8];
  endtask

  // One clock: scoreboard sampled on the falling edge, then step past rising edge.
  task automatic tick();
    ent_t e;
    logic [127:0] t;
    @(negedge clk);
    chk("cnt_a", 128'(a_xfer_cnt), 128'(cnt_model));
    chk("cnt_b", 128'(b_xfer_cnt), 128'(cnt_model[3:0]));
    chk("cnt_c", 128'(c_xfer_cnt), 128'(cnt_model[7:0]));
    chk("b_out_valid", 128'(b_out_valid), 128'(a_out_valid));
    chk("c_out_valid", 128'(c_out_valid), 128'(a_out_valid));
    if (stall_chk) begin
      chk("stall_in_ready", 128'(a_in_ready), 128'd0);
      chk("stall_out_valid", 128'(a_out_valid), 128'd1);
      if (q.size() != 0) e = q[0];
      else e = '0;
      chk("stall_out_data", 128'(a_out_data), 128'(e.da));
      chk("stall_out_mode", 128'(a_out_mode), 128'(e.mode));
    end
    last_in_xfer = in_valid & a_in_ready;
    if (rst) begin
      q.delete();
      cnt_model = 32'd0;
    end else begin
      if (in_valid) begin
        chk("b_in_ready", 128'(b_in_ready), 128'(a_in_ready));
        chk("c_in_ready", 128'(c_in_ready), 128'(a_in_ready));
        if (a_in_ready) begin
          e.mode = in_mode;
          t = sub_model(in_mode, 128'(a_in_data), 4);
          e.da = t[31:0];
          e.db = sub_model(in_mode, b_in_data, 16);
          t = sub_model(in_mode, 128'(c_in_data), 1);
          e.dc = t[7:0];
          q.push_back(e);
        end
      end
      if (a_out_valid && out_ready) begin
        chk("out_pending", 128'(q.size() != 0), 128'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("a_out_data", 128'(a_out_data), 128'(e.da));
          chk("a_out_mode", 128'(a_out_mode), 128'(e.mode));
          chk("b_out_data", b_out_data, e.db);
          chk("b_out_mode", 128'(b_out_mode), 128'(e.mode));
          chk("c_out_data", 128'(c_out_data), 128'(e.dc));
          chk("c_out_mode", 128'(c_out_mode), 128'(e.mode));
        end
        cnt_model = cnt_model + 32'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int idx;
    int hold;
    int stalls;
    int stall_n;
    logic seen;
    logic saw_wrap;
    logic [3:0] prev_b;
    logic [7:0] v;

    for (int i = 0; i < 256; i++) isbox[SBOX[i]] = 8'(i);
    vecs[0] = '{1'b0, 32'hFF53_0100, 32'h16ED_7C63};
    vecs[1] = '{1'b1, 32'h7D52_7C63, 32'h1348_0100};
    vecs[2] = '{1'b0, 32'h0000_0000, 32'h6363_6363};
    vecs[3] = '{1'b1, 32'h6363_6363, 32'h0000_0000};
    vecs[4] = '{1'b0, 32'h1020_3040, 32'hCAB7_0409};
    vecs[5] = '{1'b1, 32'hD7FE_2B67, 32'h0D0C_0B0A};

    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b1;
    set_data(32'h0);
    @(posedge clk);
    #1;
    tick();
    tick();
    chk("rst_out_valid", 128'(a_out_valid), 128'd0);
    chk("rst_out_data", 128'(a_out_data), 128'd0);
    chk("rst_out_mode", 128'(a_out_mode), 128'd0);
    chk("rst_xfer_cnt", 128'(a_xfer_cnt), 128'd0);
    chk("rst_b_out_data", b_out_data, 128'd0);
    rst = 1'b0;
    chk("rst_in_ready", 128'(a_in_ready), 128'd1);

    // Directed vectors: one beat each, exact 2-cycle latency.
    for (int i = 0; i < NV; i++) begin
      in_mode = vecs[i].mode;
      set_data(vecs[i].din);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("tbl_lat1_valid", 128'(a_out_valid), 128'd0);
      tick();
      chk("tbl_valid", 128'(a_out_valid), 128'd1);
      chk("tbl_data", 128'(a_out_data), 128'(vecs[i].dout));
      chk("tbl_mode", 128'(a_out_mode), 128'(vecs[i].mode));
      tick();
      chk("tbl_cnt", 128'(a_xfer_cnt), 128'(i + 1));
    end

    // 512 beats, mode alternating every beat, all byte values per mode.
    stalls = 0;
    for (int k = 0; k < 512; k++) begin
      v = 8'(k >> 1);
      in_mode = k[0];
      set_data({8'(v + 8'd192), 8'(v + 8'd128), 8'(v + 8'd64), v});
      in_valid = 1'b1;
      tick();
      if (!last_in_xfer) stalls++;
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("stream_stalls", 128'(stalls), 128'd0);
    chk("stream_drained", 128'(q.size()), 128'd0);
    chk("stream_cnt", 128'(a_xfer_cnt), 128'(NV + 512));

    // Backpressure: out_ready low for 3 cycles after the first out_valid.
    idx = 0; cyc = 0; hold = 0; stall_n = 0; seen = 1'b0;
    in_valid = 1'b1;
    in_mode = 1'b0;
    set_data(32'h0302_0100);
    while (cyc < 60 && !(idx == 10 && q.size() == 0)) begin
      tick();
      cyc++;
      if (stall_chk) stall_n++;
      if (last_in_xfer) idx++;
      if (idx < 10) begin
        in_mode = idx[0];
        set_data({8'(idx * 4 + 3), 8'(idx * 4 + 2), 8'(idx * 4 + 1), 8'(idx * 4)} ^ 32'h5A00_A500);
      end else begin
        in_valid = 1'b0;
      end
      if (hold > 0) hold--;
      if (!seen && a_out_valid) begin
        seen = 1'b1;
        hold = 3;
      end
      out_ready = (hold == 0);
      stall_chk = (hold > 0);
    end
    stall_chk = 1'b0;
    out_ready = 1'b1;
    chk("bp_cycles", 128'(cyc), 128'd15);
    chk("bp_beats_in", 128'(idx), 128'd10);
    chk("bp_stall_cycles", 128'(stall_n), 128'd3);
    chk("bp_drained", 128'(q.size()), 128'd0);
    chk("bp_cnt", 128'(a_xfer_cnt), 128'(NV + 522));

    // Reset with two beats in flight.
    in_valid = 1'b1;
    in_mode = 1'b1;
    set_data(32'hA1B2_C3D4);
    tick();
    set_data(32'h5566_7788);
    tick();
    chk("mid_full_valid", 128'(a_out_valid), 128'd1);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    chk("mid_rst_valid", 128'(a_out_valid), 128'd0);
    chk("mid_rst_cnt", 128'(a_xfer_cnt), 128'd0);
    chk("mid_rst_data", 128'(a_out_data), 128'd0);
    chk("mid_rst_mode", 128'(a_out_mode), 128'd0);
    chk("mid_rst_b_cnt", 128'(b_xfer_cnt), 128'd0);
    rst = 1'b0; out_ready = 1'b1;
    chk("mid_in_ready", 128'(a_in_ready), 128'd1);
    for (int k = 0; k < 4; k++) begin
      in_mode = k[0];
      set_data(32'hDEAD_BEEF ^ 32'(k));
      tick();
      chk("mid_no_ghost", 128'(a_out_valid), 128'd0);
    end

    // 17 transfers from reset: 4-bit counter wraps 15 -> 0 and ends at 1.
    saw_wrap = 1'b0;
    prev_b = b_xfer_cnt;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k == 17) in_valid = 1'b0;
      in_mode = k[0];
      set_data(32'h1111_1111 * 32'(k + 1));
      tick();
      if (prev_b == 4'd15 && b_xfer_cnt == 4'd0) saw_wrap = 1'b1;
      prev_b = b_xfer_cnt;
    end
    chk("wrap_seen", 128'(saw_wrap), 128'd1);
    chk("wrap_b_cnt", 128'(b_xfer_cnt), 128'd1);
    chk("wrap_a_cnt", 128'(a_xfer_cnt), 128'd17);
    chk("wrap_c_cnt", 128'(c_xfer_cnt), 128'd17);
    chk("final_drained", 128'(q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
